alu_issue_ctrl: RTL and testbench

//  Multicycle issue/decode front end for the 32-bit ALU. Accepts a MIPS instruction plus

---
 rtl/alu_issue_ctrl_pkg.sv | 56 +++++
 rtl/alu_decode.sv | 63 ++++++
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue/decode front end.
// ALU control codes, opcode/funct values, decode bundle, FSM states.
package alu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    CTL_AND = 3'b000,
    CTL_OR  = 3'b001,
    CTL_ADD = 3'b010,
    CTL_SLL = 3'b100,
    CTL_SRL = 3'b101,
    CTL_SUB = 3'b110,
    CTL_NOR = 3'b111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    B_RT,
    B_SEXT,
    B_ZEXT,
    B_ZERO
  } b_sel_e;

  typedef enum logic [1:0] {
    K_ALU,
    K_BEQ,
    K_BNE,
    K_ILL
  } op_kind_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  typedef struct packed {
    alu_ctl_e ctl;
    b_sel_e   b_sel;
    op_kind_e kind;
  } dec_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct decoder.
// Produces ALU control, operand-b source and op kind.
module alu_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec.ctl   = CTL_ADD;
    dec.b_sel = B_ZERO;
    dec.kind  = K_ILL;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        dec.b_sel = B_RT;
        dec.kind  = K_ALU;
        unique case (funct)
          FN_ADD:  dec.ctl = CTL_ADD;
          FN_SUB:  dec.ctl = CTL_SUB;
          FN_AND:  dec.ctl = CTL_AND;
          FN_OR:   dec.ctl = CTL_OR;
          FN_NOR:  dec.ctl = CTL_NOR;
          FN_SLL:  dec.ctl = CTL_SLL;
          FN_SRL:  dec.ctl = CTL_SRL;
          default: begin
            dec.ctl   = CTL_ADD;
            dec.b_sel = B_ZERO;
            dec.kind  = K_ILL;
          end
        endcase
      end
      (op == OP_ADDI): begin
        dec.ctl   = CTL_ADD;
        dec.b_sel = B_SEXT;
        dec.kind  = K_ALU;
      end
      (op == OP_ANDI): begin
        dec.ctl   = CTL_AND;
        dec.b_sel = B_ZEXT;
        dec.kind  = K_ALU;
      end
      (op == OP_ORI): begin
        dec.ctl   = CTL_OR;
        dec.b_sel = B_ZEXT;
        dec.kind  = K_ALU;
      end
      (op == OP_BEQ): begin
        dec.ctl   = CTL_SUB;
        dec.b_sel = B_RT;
        dec.kind  = K_BEQ;
      end
      (op == OP_BNE): begin
        dec.ctl   = CTL_SUB;
        dec.b_sel = B_RT;
        dec.kind  = K_BNE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multicycle issue front end: decode, drive external ALU,
// capture its result, return it on an output handshake.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int W   = 32,
  parameter int SHW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    instr,
  input  logic [W-1:0]   rs_data,
  input  logic [W-1:0]   rt_data,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [SHW-1:0] alu_shamt,
  output logic [2:0]     alu_ctl,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_zero,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   result,
  output logic           branch_taken,
  output logic           illegal
);

  state_e   state_q, state_d;
  dec_t     dec;
  alu_ctl_e ctl_q;
  op_kind_e kind_q;
  logic [W-1:0]   a_q, b_q, b_d, res_q;
  logic [SHW-1:0] sh_q, sh_d;
  logic           br_q, ill_q, accept, is_shift;
  logic           unused_bits;

  assign unused_bits = ^instr[25:16];

  alu_decode u_dec (
    .op    (instr[31:26]),
    .funct (instr[5:0]),
    .dec   (dec)
  );

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = (state_q == S_DONE) && !reset;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign is_shift = (dec.kind == K_ALU) &&
                    ((dec.ctl == CTL_SLL) ||
                     (dec.ctl == CTL_SRL));

  always_comb begin
    b_d  = '0;
    sh_d = '0;
    unique case (dec.b_sel)
      B_RT:    b_d = rt_data;
      B_SEXT:  b_d = {{(W-16){instr[15]}}, instr[15:0]};
      B_ZEXT:  b_d = {{(W-16){1'b0}}, instr[15:0]};
      default: b_d = '0;
    endcase
    if (is_shift) sh_d = {{(SHW-5){1'b0}}, instr[10:6]};
  end

  // Operand regs hold until the next accept; result regs load in EXEC only.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q  <= CTL_AND;
      kind_q <= K_ALU;
      a_q    <= '0;
      b_q    <= '0;
      sh_q   <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      if (accept) begin
        ctl_q  <= dec.ctl;
        kind_q <= dec.kind;
        a_q    <= (dec.kind == K_ILL) ? '0 : rs_data;
        b_q    <= b_d;
        sh_q   <= sh_d;
      end
      if (state_q == S_EXEC) begin
        res_q <= (kind_q == K_ALU) ? alu_result : '0;
        br_q  <= ((kind_q == K_BEQ) && alu_zero) ||
                 ((kind_q == K_BNE) && !alu_zero);
        ill_q <= (kind_q == K_ILL);
      end
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_shamt    = sh_q;
  assign alu_ctl      = ctl_q;
  assign result       = res_q;
  assign branch_taken = br_q;
  assign illegal      = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural ALU alongside.
// Directed scenarios followed by randomized instructions.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [5:0]  alu_shamt;
  logic [2:0]  alu_ctl;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        branch_taken, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.W(32), .SHW(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_shamt    (alu_shamt),
    .alu_ctl      (alu_ctl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  // Stand-in for the external alu32.
  always_comb begin
    alu_result = '0;
    case (alu_ctl)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a + alu_b;
      3'b110: alu_result = alu_a - alu_b;
      3'b111: alu_result = ~(alu_a | alu_b);
      3'b100: alu_result = alu_b << alu_shamt;
      3'b101: alu_result = alu_b >> alu_shamt;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn,
                                        input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op,
                                        input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  // Reference: what a MIPS issue stage should produce for one instruction.
  function automatic void model(input  logic [31:0] ins, a, b,
                                output logic [31:0] res,
                                output logic        br, ill,
                                output logic [2:0]  ctl,
                                output logic [31:0] ea, eb,
                                output logic [5:0]  sh);
    logic [5:0]  op = ins[31:26];
    logic [5:0]  fn = ins[5:0];
    logic [4:0]  s  = ins[10:6];
    logic [31:0] se = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] ze = {16'h0, ins[15:0]};
    res = 0; br = 0; ill = 0; ctl = 3'b010;
    ea = a; eb = b; sh = 0;
    if (op == 6'h00 && fn == 6'h20) begin ctl = 3'b010; res = a + b; end
    else if (op == 6'h00 && fn == 6'h22) begin ctl = 3'b110; res = a - b; end
    else if (op == 6'h00 && fn == 6'h24) begin ctl = 3'b000; res = a & b; end
    else if (op == 6'h00 && fn == 6'h25) begin ctl = 3'b001; res = a | b; end
    else if (op == 6'h00 && fn == 6'h27) begin ctl = 3'b111; res = ~(a | b); end
    else if (op == 6'h00 && fn == 6'h00) begin
      ctl = 3'b100; sh = {1'b0, s}; res = b << s;
    end else if (op == 6'h00 && fn == 6'h02) begin
      ctl = 3'b101; sh = {1'b0, s}; res = b >> s;
    end else if (op == 6'h08) begin ctl = 3'b010; eb = se; res = a + se; end
    else if (op == 6'h0C) begin ctl = 3'b000; eb = ze; res = a & ze; end
    else if (op == 6'h0D) begin ctl = 3'b001; eb = ze; res = a | ze; end
    else if (op == 6'h04) begin ctl = 3'b110; br = (a == b); end
    else if (op == 6'h05) begin ctl = 3'b110; br = (a != b); end
    else begin ill = 1; ea = 0; eb = 0; end
  endfunction

  // Called at a falling edge; returns at the falling edge back in IDLE.
  task automatic run_op(input logic [31:0] ins, a, b, input int stall);
    logic [31:0] er, ea, eb;
    logic        ebr, eill;
    logic [2:0]  ectl;
    logic [5:0]  esh;
    int          n = 0;
    model(ins, a, b, er, ebr, eill, ectl, ea, eb, esh);
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; instr = ins; rs_data = a; rt_data = b;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 0; instr = $urandom;
    rs_data = $urandom; rt_data = $urandom;
    chk("exec_ctl", alu_ctl, ectl);
    chk("exec_a", alu_a, ea);
    chk("exec_b", alu_b, eb);
    chk("exec_shamt", alu_shamt, esh);
    chk("exec_out_valid", out_valid, 0);
    chk("exec_in_ready", in_ready, 0);
    @(negedge clk);
    chk("done_out_valid", out_valid, 1);
    chk("done_result", result, er);
    chk("done_branch", branch_taken, ebr);
    chk("done_illegal", illegal, eill);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      instr = $urandom;
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, er);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [31:0] ins, a, b;
    int          sel;
    in_valid = 1;
    instr = rtype(6'h22, 5'd0);
    rs_data = 32'h1234;
    rt_data = 32'h0001;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctl", alu_ctl, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_result", result, 0);
    in_valid = 0;
    reset = 0;
    @(negedge clk);

    // add, shifts, immediates, branches
    run_op(rtype(6'h20, 5'd0), 32'd5, 32'd7, 0);
    run_op(rtype(6'h00, 5'd4), 32'd9, 32'h0000000F, 0);
    run_op(rtype(6'h02, 5'd31), 32'd9, 32'h80000000, 0);
    run_op(itype(6'h08, 16'hFFFF), 32'd1, 32'd3, 0);
    run_op(itype(6'h04, 16'h0010), 32'h55, 32'h55, 0);
    run_op(itype(6'h05, 16'h0010), 32'h55, 32'h55, 0);
    // backpressure with ignored in_valid pulses
    run_op(rtype(6'h22, 5'd0), 32'd3, 32'd10, 5);
    // lw and a bad R-type funct
    run_op(itype(6'h23, 16'h0004), 32'd8, 32'd9, 0);
    run_op(rtype(6'h18, 5'd0), 32'd8, 32'd9, 1);

    // Reset while in EXEC
    in_valid = 1; instr = rtype(6'h20, 5'd0);
    rs_data = 32'd100; rt_data = 32'd23;
    @(negedge clk);
    instr = rtype(6'h22, 5'd0);
    reset = 1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_ctl", alu_ctl, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_result", result, 0);
    @(negedge clk);
    reset = 0;
    in_valid = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_ctl", alu_ctl, 0);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
    end

    // Randomized mix
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 14);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      ins = $urandom;
      case (sel)
        0: ins = {6'h00, ins[25:6], 6'h20};
        1: ins = {6'h00, ins[25:6], 6'h22};
        2: ins = {6'h00, ins[25:6], 6'h24};
        3: ins = {6'h00, ins[25:6], 6'h25};
        4: ins = {6'h00, ins[25:6], 6'h27};
        5: ins = {6'h00, ins[25:6], 6'h00};
        6: ins = {6'h00, ins[25:6], 6'h02};
        7: ins = {6'h08, ins[25:0]};
        8: ins = {6'h0C, ins[25:0]};
        9: ins = {6'h0D, ins[25:0]};
        10: ins = {6'h04, ins[25:0]};
        11: ins = {6'h05, ins[25:0]};
        12: ins = {6'h23, ins[25:0]};
        13: ins = {6'h00, ins[25:6], 6'h18};
        default: ;
      endcase
      run_op(ins, a, b, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
